// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state/status codes, the seconds
// limit and the load clamp for seconds.
package timer_pkg;

  localparam logic [1:0] STATUS_IDLE    = 2'b00;
  localparam logic [1:0] STATUS_RUNNING = 2'b01;
  localparam logic [1:0] STATUS_PAUSED  = 2'b10;
  localparam logic [1:0] STATUS_EXPIRED = 2'b11;

  localparam logic [5:0] SEC_MAX = 6'd59;

  // The state encoding is the status code, so status is the state register itself.
  typedef enum logic [1:0] {
    ST_IDLE    = STATUS_IDLE,
    ST_RUNNING = STATUS_RUNNING,
    ST_PAUSED  = STATUS_PAUSED,
    ST_EXPIRED = STATUS_EXPIRED
  } timer_state_e;

  function automatic logic [5:0] clamp_sec(input logic [5:0] sec);
    return (sec > SEC_MAX) ? SEC_MAX : sec;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/preset inputs and time/status outputs of the countdown timer.
interface countdown_timer_if;

  logic       start;
  logic       stop;
  logic       clear;
  logic       load;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;
  logic       done;
  logic       alarm;

  modport master (
    output start, stop, clear, load, load_min, load_sec,
    input  minutes, seconds, status, done, alarm
  );

  modport slave (
    input  start, stop, clear, load, load_min, load_sec,
    output minutes, seconds, status, done, alarm
  );

endinterface

// File: rtl/sec_down_counter.sv
// Mod-60 seconds down-counter; borrow flags the 00 -> 59 wrap that should
// take one from the minutes.
module sec_down_counter
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       dec,
  output logic [5:0] count,
  output logic       borrow
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= 6'd0;
    else if (clear)
      count <= 6'd0;
    else if (load)
      count <= clamp_sec(load_val);
    else if (dec)
      count <= (count == 6'd0) ? SEC_MAX : count - 6'd1;
  end

  assign borrow = dec && (count == 6'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer: control FSM and minutes register, with the seconds
// digit delegated to sec_down_counter.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int MAX_MIN = 99
) (
  input logic              clk,
  input logic              rst,
  countdown_timer_if.slave bus
);

  localparam logic [6:0] MIN_LIMIT = 7'(MAX_MIN);

  timer_state_e state, next_state;
  logic [6:0]   min_q, min_d;
  logic         done_q, done_d;
  logic         sec_clear, sec_load, sec_dec;
  logic [5:0]   sec_count;
  logic         sec_borrow;
  logic [6:0]   load_min_clamped;
  logic         count_zero, last_second;

  sec_down_counter u_sec (
    .clk      (clk),
    .rst      (rst),
    .clear    (sec_clear),
    .load     (sec_load),
    .load_val (bus.load_sec),
    .dec      (sec_dec),
    .count    (sec_count),
    .borrow   (sec_borrow)
  );

  assign load_min_clamped = (bus.load_min > MIN_LIMIT) ? MIN_LIMIT : bus.load_min;
  assign count_zero       = (min_q == 7'd0) && (sec_count == 6'd0);
  assign last_second      = (min_q == 7'd0) && (sec_count == 6'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      min_q  <= 7'd0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      min_q  <= min_d;
      done_q <= done_d;
    end
  end

  // Priority is clear > load > stop > start in every state.
  always_comb begin
    next_state = state;
    min_d      = min_q;
    done_d     = 1'b0;
    sec_clear  = 1'b0;
    sec_load   = 1'b0;
    sec_dec    = 1'b0;

    if (bus.clear) begin
      next_state = ST_IDLE;
      min_d      = 7'd0;
      sec_clear  = 1'b1;
    end else if (bus.load && (state != ST_RUNNING)) begin
      next_state = ST_IDLE;
      min_d      = load_min_clamped;
      sec_load   = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_PAUSED: begin
          if (!bus.stop && bus.start && !count_zero)
            next_state = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (bus.stop) begin
            next_state = ST_PAUSED;
          end else if (count_zero) begin
            next_state = ST_EXPIRED;
          end else begin
            sec_dec = 1'b1;
            if (sec_borrow)
              min_d = min_q - 7'd1;
            // The decrement that lands on 00:00 expires on the same edge.
            if (last_second) begin
              next_state = ST_EXPIRED;
              done_d     = 1'b1;
            end
          end
        end
        ST_EXPIRED: begin
          next_state = ST_EXPIRED;
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.minutes = min_q;
  assign bus.seconds = sec_count;
  assign bus.status  = state;
  assign bus.done    = done_q;
  assign bus.alarm   = (state == ST_EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues the expected
// MM:SS/status/done/alarm for each cycle and a monitor compares them.
module tb_countdown_timer;

  typedef struct {
    int         target;
    logic [6:0] m;
    logic [5:0] s;
    logic [1:0] st;
    logic       d;
    logic       a;
  } exp_t;

  logic clk;
  logic rst;
  logic async_probe;
  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  string name_q[$];

  countdown_timer_if bus ();

  countdown_timer #(.MAX_MIN(99)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_expect(input int target, input logic [6:0] em, input logic [5:0] es,
                             input logic [1:0] est, input logic ed, input string nm);
    exp_t e;
    e.target = target;
    e.m      = em;
    e.s      = es;
    e.st     = est;
    e.d      = ed;
    e.a      = (est == 2'b11);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One cycle of inputs; the expectation applies after the following rising edge.
  task automatic apply_stimulus(input logic st, input logic sp, input logic cl, input logic ld,
                                input logic [6:0] lm, input logic [5:0] ls,
                                input logic [6:0] em, input logic [5:0] es,
                                input logic [1:0] est, input logic ed, input string nm);
    @(negedge clk);
    bus.start    = st;
    bus.stop     = sp;
    bus.clear    = cl;
    bus.load     = ld;
    bus.load_min = lm;
    bus.load_sec = ls;
    push_expect(cyc + 1, em, es, est, ed, nm);
  endtask

  task automatic check_output(input exp_t e, input string nm);
    checks++;
    if (bus.minutes !== e.m || bus.seconds !== e.s || bus.status !== e.st ||
        bus.done !== e.d || bus.alarm !== e.a) begin
      errors++;
      $display("[TB] FAIL %s: got %0d:%0d status=%0d done=%0d alarm=%0d, expected %0d:%0d status=%0d done=%0d alarm=%0d",
               nm, bus.minutes, bus.seconds, bus.status, bus.done, bus.alarm,
               e.m, e.s, e.st, e.d, e.a);
    end
  endtask

  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk or posedge async_probe);
      while (exp_q.size() > 0 && exp_q[0].target <= cyc) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.target < cyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL %s: sample missed, now cycle %0d, required cycle %0d", nm, cyc, e.target);
        end else begin
          check_output(e, nm);
        end
      end
    end
  end

  initial begin
    int rem;
    int waited;
    cyc          = 0;
    checks       = 0;
    errors       = 0;
    async_probe  = 1'b0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.clear    = 1'b0;
    bus.load     = 1'b0;
    bus.load_min = 7'd0;
    bus.load_sec = 6'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    apply_stimulus(0, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd0, 2'b00, 0, "reset_state");
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd0, 2'b00, 0, "start_at_zero");

    // 01:02 runs down through a minute borrow to expiry.
    apply_stimulus(0, 0, 0, 1, 7'd1, 6'd2, 7'd1, 6'd2, 2'b00, 0, "load_0102");
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd1, 6'd2, 2'b01, 0, "enter_run");
    for (int k = 1; k <= 62; k++) begin
      rem = 62 - k;
      apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'(rem / 60), 6'(rem % 60),
                     (rem == 0) ? 2'b11 : 2'b01, (rem == 0), "run_0102");
    end
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd0, 2'b11, 0, "expired_start");
    apply_stimulus(1, 1, 0, 0, 7'd0, 6'd0, 7'd0, 6'd0, 2'b11, 0, "expired_stop");
    apply_stimulus(0, 0, 0, 1, 7'd0, 6'd3, 7'd0, 6'd3, 2'b00, 0, "expired_load");

    // Pause and resume.
    apply_stimulus(0, 0, 0, 1, 7'd0, 6'd5, 7'd0, 6'd5, 2'b00, 0, "load_0005");
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd5, 2'b01, 0, "run_0005");
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd4, 2'b01, 0, "run_0004");
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd3, 2'b01, 0, "run_0003");
    apply_stimulus(0, 1, 0, 0, 7'd0, 6'd0, 7'd0, 6'd3, 2'b10, 0, "pause");
    apply_stimulus(0, 1, 0, 0, 7'd0, 6'd0, 7'd0, 6'd3, 2'b10, 0, "pause_hold");
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd3, 2'b01, 0, "resume");
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd2, 2'b01, 0, "resume_0002");
    apply_stimulus(0, 1, 0, 0, 7'd0, 6'd0, 7'd0, 6'd2, 2'b10, 0, "pause_again");

    // Clamping on load.
    apply_stimulus(0, 0, 0, 1, 7'd120, 6'd63, 7'd99, 6'd59, 2'b00, 0, "load_clamp");

    // Start+stop together, clear over load, load ignored while running.
    apply_stimulus(0, 0, 0, 1, 7'd0, 6'd10, 7'd0, 6'd10, 2'b00, 0, "load_0010");
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd10, 2'b01, 0, "run_0010");
    apply_stimulus(1, 1, 0, 0, 7'd0, 6'd0, 7'd0, 6'd10, 2'b10, 0, "start_stop_run");
    apply_stimulus(0, 0, 1, 1, 7'd0, 6'd7, 7'd0, 6'd0, 2'b00, 0, "clear_over_load");
    apply_stimulus(0, 0, 0, 1, 7'd0, 6'd4, 7'd0, 6'd4, 2'b00, 0, "load_0004");
    apply_stimulus(1, 1, 0, 0, 7'd0, 6'd0, 7'd0, 6'd4, 2'b00, 0, "start_stop_idle");
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd4, 2'b01, 0, "run_0004b");
    apply_stimulus(1, 0, 0, 1, 7'd0, 6'd50, 7'd0, 6'd3, 2'b01, 0, "load_in_run");
    apply_stimulus(1, 0, 1, 0, 7'd0, 6'd0, 7'd0, 6'd0, 2'b00, 0, "clear_in_run");

    // Asynchronous reset in the middle of a run at 00:30.
    apply_stimulus(0, 0, 0, 1, 7'd0, 6'd40, 7'd0, 6'd40, 2'b00, 0, "load_0040");
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd40, 2'b01, 0, "run_0040");
    for (int k = 1; k <= 10; k++)
      apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'(40 - k), 2'b01, 0, "run_to_0030");
    @(negedge clk);
    #1 rst = 1'b1;
    push_expect(cyc, 7'd0, 6'd0, 2'b00, 0, "async_reset");
    #2 async_probe = 1'b1;
    @(negedge clk);
    async_probe = 1'b0;
    rst         = 1'b0;
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd0, 2'b00, 0, "start_after_rst");
    apply_stimulus(1, 0, 0, 0, 7'd0, 6'd0, 7'd0, 6'd0, 2'b00, 0, "start_after_rst2");

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter MAX_MIN, default 99, is the largest loadable minutes value.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  level, sampled each cycle; run request.
REQ-005 stop  input  1  level, sampled each cycle; pause request.
REQ-006 clear  input  1  synchronous clear to idle and 00:00.
REQ-007 load  input  1  one-cycle strobe; captures load_min and load_sec.
REQ-008 load_min  input  7  preset minutes.
REQ-009 load_sec  input  6  preset seconds.
REQ-010 minutes  output  7  remaining minutes, registered.
REQ-011 seconds  output  6  remaining seconds, registered.
REQ-012 status  output  2  state code: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED.
REQ-013 done  output  1  one-cycle pulse on expiry.
REQ-014 alarm  output  1  level; high while in EXPIRED.

Function
REQ-015 The block SHALL have four states, IDLE, RUNNING, PAUSED and EXPIRED, reported on status.
REQ-016 Input priority SHALL be, in all states: clear > load > stop > start.
REQ-017 clear SHALL force IDLE, 00:00, done=0 and alarm=0 on the next edge.
REQ-018 load SHALL be accepted in IDLE, PAUSED and EXPIRED: it captures the preset and enters IDLE; load SHALL be ignored in RUNNING.
REQ-019 load clamping: load_sec >59 SHALL be stored as 59; load_min >MAX_MIN SHALL be stored as MAX_MIN.
REQ-020 IDLE or PAUSED with start=1, stop=0 and a count ≠00:00 SHALL enter RUNNING; with a count of 00:00, start SHALL be ignored.
REQ-021 RUNNING SHALL decrement the count by one second on every clk cycle in which the state is RUNNING and stop=0.
REQ-022 Decrement rule: if seconds>0, seconds−1; else seconds=59 and minutes−1.
REQ-023 RUNNING with stop=1 SHALL enter PAUSED with no decrement that cycle.
REQ-024 When the decrement produces 00:00, the same edge SHALL enter EXPIRED and assert done for exactly one cycle.
REQ-025 EXPIRED SHALL hold 00:00 with alarm=1; start and stop SHALL be ignored; only clear, load or rst exit EXPIRED.
REQ-026 Simultaneous start and stop SHALL resolve to stop: IDLE stays IDLE, RUNNING enters PAUSED.
REQ-027 Count SHALL never underflow below 00:00 or exceed MAX_MIN:59.

Reset
REQ-028 rst=1 SHALL immediately and asynchronously force IDLE, minutes=0, seconds=0, done=0 and alarm=0, including mid-run.
REQ-029 After rst deasserts, the block SHALL ignore start until a nonzero load is performed.

Structure
REQ-030 The state encodings, SEC_MAX=59 and the status codes SHALL live in a shared package, timer_pkg.
REQ-031 The mod-60 seconds down-counter with borrow-out SHALL be one sub-module, sec_down_counter; the FSM and the minutes logic stay in the top level.

Verification
REQ-032 load 01:02, start held -> 01:01, 01:00, 00:59 on consecutive cycles; 00:00 after 62 cycles with done pulsed once and status=11.
REQ-033 load 00:05, run 2 cycles, stop -> holds 00:03 with status=10; start -> resumes at 00:02.
REQ-034 load_min=120 and load_sec=63 -> stored as 99:59 (MAX_MIN=99).
REQ-035 start and stop together in RUNNING at 00:10 -> PAUSED at 00:10; clear and load together -> IDLE at 00:00.
REQ-036 rst asserted mid-run at 00:30 -> outputs 00:00 and status=00 before the next edge; start after release -> remains IDLE.
REQ-037 In EXPIRED, start -> no change and alarm stays 1; load 00:03 -> IDLE at 00:03 with alarm=0.
